// File: rtl/lr_seq_ctrl.sv
// Sequencing FSM for the linear-regression accumulation datapath.
// Define LR_ABORT_EN to add an abort input that cancels a batch in progress.
module lr_seq_ctrl #(
  parameter int N_SAMPLES = 150,
  parameter int CALC_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
`ifdef LR_ABORT_EN
  input  logic       abort,
`endif
  output logic       in_ready,
  output logic       ldx,
  output logic       ldy,
  output logic       initsumx,
  output logic       initsumy,
  output logic       initsumxx,
  output logic       initsumxy,
  output logic       ldsumx,
  output logic       ldsumy,
  output logic       ldsumxx,
  output logic       ldsumxy,
  output logic [8:0] count,
  output logic       en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, INIT, WAIT_S, ACC, CALC, DONE} state_t;

  localparam logic [8:0] N_LAST    = N_SAMPLES[8:0];
  localparam logic [3:0] WAIT_INIT = 4'(CALC_WAIT - 1);

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       abort_hit;
  logic       last_sample;

`ifdef LR_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign last_sample = (count + 9'd1) == N_LAST;

  // An abort leaves count frozen so the source can see how far the batch got.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      en       <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (abort_hit) begin
        en <= 1'b0;
      end else begin
        case (state)
          IDLE:    if (start) en <= 1'b0;
          INIT:    count <= '0;
          ACC: begin
            count    <= count + 9'd1;
            wait_cnt <= WAIT_INIT;
          end
          CALC:    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          DONE:    en <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    ldx       = 1'b0;
    ldy       = 1'b0;
    initsumx  = 1'b0;
    initsumy  = 1'b0;
    initsumxx = 1'b0;
    initsumxy = 1'b0;
    ldsumx    = 1'b0;
    ldsumy    = 1'b0;
    ldsumxx   = 1'b0;
    ldsumxy   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nx = INIT;
      INIT: begin
        busy      = 1'b1;
        initsumx  = 1'b1;
        initsumy  = 1'b1;
        initsumxx = 1'b1;
        initsumxy = 1'b1;
        state_nx  = WAIT_S;
      end
      WAIT_S: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        ldx      = in_valid;
        ldy      = in_valid;
        if (in_valid) state_nx = ACC;
      end
      ACC: begin
        busy     = 1'b1;
        ldsumx   = 1'b1;
        ldsumy   = 1'b1;
        ldsumxx  = 1'b1;
        ldsumxy  = 1'b1;
        state_nx = last_sample ? CALC : WAIT_S;
      end
      CALC: begin
        busy = 1'b1;
        if (wait_cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort_hit) state_nx = IDLE;
  end

endmodule

// File: tb/tb_lr_seq_ctrl.sv
// Self-checking bench for lr_seq_ctrl: a behavioural datapath and event
// scoreboard watch the strobes while randomized and directed batches run.
module tb_lr_seq_ctrl;
  localparam int N  = 150;
  localparam int CW = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic in_ready, ldx, ldy, initsumx, initsumy, initsumxx, initsumxy;
  logic ldsumx, ldsumy, ldsumxx, ldsumxy, en, busy, done;
  logic [8:0] count;
`ifdef LR_ABORT_EN
  logic abort = 1'b0;
`endif

  int errors = 0, checks = 0;
  int ldx_cnt = 0, ldsum_cnt = 0, init_cnt = 0, done_cnt = 0;
  int viol_cnt = 0, count_err = 0, accepts = 0;
  longint xr = 0, yr = 0, sx = 0, sy = 0, sxx = 0, sxy = 0;

  lr_seq_ctrl #(.N_SAMPLES(N), .CALC_WAIT(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
`ifdef LR_ABORT_EN
    .abort(abort),
`endif
    .in_ready(in_ready), .ldx(ldx), .ldy(ldy),
    .initsumx(initsumx), .initsumy(initsumy), .initsumxx(initsumxx), .initsumxy(initsumxy),
    .ldsumx(ldsumx), .ldsumy(ldsumy), .ldsumxx(ldsumxx), .ldsumxy(ldsumxy),
    .count(count), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath plus protocol scoreboard; the source presents x=i, y=2i+1.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready && (count != 9'(accepts))) count_err++;
      if ((ldx || ldy) && (!in_ready || !in_valid || ldx != ldy)) viol_cnt++;
      if ((initsumx | initsumy | initsumxx | initsumxy) &&
          (ldsumx | ldsumy | ldsumxx | ldsumxy)) viol_cnt++;
      if (count > 9'(N)) viol_cnt++;
      if (initsumx && initsumy && initsumxx && initsumxy) begin
        sx = 0; sy = 0; sxx = 0; sxy = 0; accepts = 0; init_cnt++;
      end
      if (ldsumx && ldsumy && ldsumxx && ldsumxy) begin
        sx += xr; sy += yr; sxx += xr * xr; sxy += xr * yr; ldsum_cnt++;
      end
      if (ldx) begin
        xr = longint'(accepts); yr = 2 * longint'(accepts) + 1; accepts++; ldx_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  function automatic longint calc_b1();
    longint num, den;
    num = longint'(N) * sxy - sx * sy;
    den = longint'(N) * sxx - sx * sx;
    return (den == 0) ? -1 : (num * 1024) / den;
  endfunction

  function automatic longint calc_b0();
    return (sy * 1024 - calc_b1() * sx) / (longint'(N) * 1024);
  endfunction

  task automatic kick(input bit hold);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 if (!hold) start = 1'b0;
  endtask

  // n counts cycles after the start edge; poke_count >= 0 pulses start while busy.
  task automatic wait_done(input bit bubble, input int poke_count,
                           output int n, output int last_acc, output bit ok);
    bit poked = 1'b0;
    int poke_left = 0;
    n = 0; last_acc = -1; ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      n++;
      if (in_ready && in_valid) last_acc = n;
      if (done) begin ok = 1'b1; break; end
      if (poke_count >= 0 && !poked && in_ready && count == 9'(poke_count)) begin
        poked = 1'b1; poke_left = 2;
      end
      @(posedge clk); #1;
      if (bubble) in_valid = ($urandom_range(0, 2) == 0);
      if (poke_left > 0) begin start = 1'b1; poke_left--; end
      else if (poked) start = 1'b0;
    end
    if (!ok) begin errors++; $display("[TB] FAIL done_timeout: got no done, want done"); end
    checks++;
  endtask

  task automatic check_batch(input string tag, input int n, input int want_n,
                             input int ldx0, input int ldsum0, input int init0, input int done0);
    checks++; if (n != want_n) begin errors++; $display("[TB] FAIL %s_latency: got %0d want %0d", tag, n, want_n); end
    checks++; if (count !== 9'(N)) begin errors++; $display("[TB] FAIL %s_count: got %0d want %0d", tag, count, N); end
    @(negedge clk); #1;
    checks++; if (en !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL %s_after: got en=%b busy=%b done=%b want 1 0 0", tag, en, busy, done); end
    checks++; if (ldx_cnt - ldx0 != N) begin errors++; $display("[TB] FAIL %s_ldx: got %0d want %0d", tag, ldx_cnt - ldx0, N); end
    checks++; if (ldsum_cnt - ldsum0 != N) begin errors++; $display("[TB] FAIL %s_ldsum: got %0d want %0d", tag, ldsum_cnt - ldsum0, N); end
    checks++; if (init_cnt - init0 != 1) begin errors++; $display("[TB] FAIL %s_init: got %0d want 1", tag, init_cnt - init0); end
    checks++; if (done_cnt - done0 != 1) begin errors++; $display("[TB] FAIL %s_done_cnt: got %0d want 1", tag, done_cnt - done0); end
    checks++; if (calc_b1() != 2048) begin errors++; $display("[TB] FAIL %s_b1: got %0d want 2048", tag, calc_b1()); end
    checks++; if (calc_b0() != 1) begin errors++; $display("[TB] FAIL %s_b0: got %0d want 1", tag, calc_b0()); end
    checks++; if (viol_cnt != 0 || count_err != 0) begin
      errors++; $display("[TB] FAIL %s_protocol: got viol=%0d count_err=%0d want 0 0", tag, viol_cnt, count_err); end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, ldx, ldy, initsumx, initsumy, initsumxx, initsumxy, ldsumx, ldsumy,
                   ldsumxx, ldsumxy, en, busy, done} !== 14'd0 || count !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got nonzero (count=%0d busy=%b en=%b) want all 0", count, busy, en); end
  endtask

  task automatic test_full_batch();
    int n, la; bit ok;
    int l0 = ldx_cnt, s0 = ldsum_cnt, i0 = init_cnt, d0 = done_cnt;
    in_valid = 1'b1;
    kick(1'b0);
    wait_done(1'b0, -1, n, la, ok);
    check_batch("full", n, 2 * N + CW + 2, l0, s0, i0, d0);
  endtask

  task automatic test_bubbled();
    int n, la; bit ok;
    int l0 = ldx_cnt, s0 = ldsum_cnt, i0 = init_cnt, d0 = done_cnt;
    in_valid = 1'b0;
    kick(1'b0);
    wait_done(1'b1, -1, n, la, ok);
    check_batch("bubbled", n, la + 2 + CW, l0, s0, i0, d0);
    in_valid = 1'b1;
  endtask

  task automatic test_start_while_busy();
    int n, la; bit ok;
    int l0 = ldx_cnt, s0 = ldsum_cnt, i0 = init_cnt, d0 = done_cnt;
    kick(1'b0);
    wait_done(1'b0, 40, n, la, ok);
    check_batch("busy_start", n, 2 * N + CW + 2, l0, s0, i0, d0);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || init_cnt - i0 != 1) begin
      errors++; $display("[TB] FAIL busy_start_restart: got busy=%b inits=%0d want 0 1", busy, init_cnt - i0); end
  endtask

  task automatic test_reset_mid_batch();
    int d0;
    bit seen = 1'b0;
    kick(1'b0);
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (in_ready && in_valid && count == 9'd5) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL midrst_reach: got no count=5, want count=5"); end
    d0 = done_cnt;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, ldx, ldy, initsumx, initsumy, initsumxx, initsumxy, ldsumx, ldsumy,
                   ldsumxx, ldsumxy, en, busy, done} !== 14'd0 || count !== 9'd0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got count=%0d busy=%b in_ready=%b want all 0", count, busy, in_ready); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_cnt != d0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_no_done: got dones=%0d busy=%b want 0 0", done_cnt - d0, busy); end
  endtask

  task automatic test_back_to_back();
    int n, la; bit ok;
    int l0 = ldx_cnt, s0 = ldsum_cnt, i0 = init_cnt, d0 = done_cnt;
    kick(1'b1);
    wait_done(1'b0, -1, n, la, ok);
    checks++; if (n != 2 * N + CW + 2) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want %0d", n, 2 * N + CW + 2); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || en !== 1'b1 || count !== 9'(N)) begin
      errors++; $display("[TB] FAIL b2b_idle: got busy=%b en=%b count=%0d want 0 1 %0d", busy, en, count, N); end
    @(negedge clk);
    checks++; if (initsumx !== 1'b1 || en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_init: got init=%b en=%b busy=%b want 1 0 1", initsumx, en, busy); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (count !== 9'd0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_count: got count=%0d in_ready=%b want 0 1", count, in_ready); end
    wait_done(1'b0, -1, n, la, ok);
    @(negedge clk); #1;
    checks++; if (done_cnt - d0 != 2 || init_cnt - i0 != 2 || ldx_cnt - l0 != 2 * N || ldsum_cnt - s0 != 2 * N) begin
      errors++; $display("[TB] FAIL b2b_totals: got dones=%0d inits=%0d want 2 2", done_cnt - d0, init_cnt - i0); end
  endtask

`ifdef LR_ABORT_EN
  task automatic test_abort();
    int n, la, d0, l0, s0, i0; bit ok;
    bit seen = 1'b0;
    kick(1'b0);
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (ldsumx && count == 9'd74) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL abort_reach: got no count=74, want count=74"); end
    d0 = done_cnt;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || count !== 9'd75 || en !== 1'b0 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_state: got busy=%b count=%0d en=%b want 0 75 0", busy, count, en); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (done_cnt != d0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    l0 = ldx_cnt; s0 = ldsum_cnt; i0 = init_cnt; d0 = done_cnt;
    kick(1'b0);
    wait_done(1'b0, -1, n, la, ok);
    check_batch("post_abort", n, 2 * N + CW + 2, l0, s0, i0, d0);
  endtask
`endif

  initial begin
    test_reset();
    test_full_batch();
    test_bubbled();
    test_start_while_busy();
    test_reset_mid_batch();
    test_back_to_back();
`ifdef LR_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
